// File: rtl/rob_pkg.sv
// Shared reorder buffer types: entry layout, tag and pointer widths.
package rob_pkg;
  localparam int ROB_WIDTH   = 31;
  localparam int ROB_TAG_MSB = 2;
  localparam int DEPTH       = 2 ** (ROB_TAG_MSB + 1);

  typedef logic [ROB_TAG_MSB:0]   rob_tag_t;
  // Extra MSB is the wrap bit that separates full from empty.
  typedef logic [ROB_TAG_MSB+1:0] rob_ptr_t;

  typedef struct packed {
    logic                 busy;
    logic                 ready;
    logic                 writesReg;
    logic [4:0]           rd;
    logic [ROB_WIDTH:0]   value;
  } rob_entry_t;
endpackage

// File: rtl/common_data_bus.sv
// Common data bus carrying one result broadcast per cycle, addressed by ROB tag.
// No handshake: a broadcast is valid for exactly the cycle validBroadcast is high.
interface commonDataBus #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2
) ();
  logic [WIDTH:0] result;
  logic [ROB:0]   robEntry;
  logic           validBroadcast;

  modport reorder_buffer (input result, input robEntry, input validBroadcast);
  modport arbiter        (output result, output robEntry, output validBroadcast);
endinterface

// File: rtl/rob_read_port.sv
// Operand lookup for one entry with same-cycle CDB forwarding; purely combinational.
// No backpressure: the answer is valid in the same cycle the tag is presented.
module rob_read_port
  import rob_pkg::*;
(
  input  rob_entry_t           entry_i,
  input  logic                 hit_i,
  input  logic [ROB_WIDTH:0]   cdbResult_i,
  output logic                 ready_o,
  output logic [ROB_WIDTH:0]   value_o
);
  assign ready_o = entry_i.busy && (entry_i.ready || hit_i);

  always_comb begin
    value_o = '0;
    if (entry_i.busy) begin
      value_o = hit_i ? cdbResult_i : entry_i.value;
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order circular reorder buffer; CDB capture in 1 cycle, retire 1 cycle after ready.
// Backpressure: allocReady drops when full, judged from registered pointers only.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int WIDTH = ROB_WIDTH,
  parameter int ROB   = ROB_TAG_MSB
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   allocValid,
  input  logic [4:0]             allocRd,
  input  logic                   allocWritesReg,
  output logic                   allocReady,
  output logic [ROB:0]           allocRob,
  commonDataBus.reorder_buffer   dataBus,
  input  logic [ROB:0]           readRobA,
  input  logic [ROB:0]           readRobB,
  output logic [WIDTH:0]         readValueA,
  output logic [WIDTH:0]         readValueB,
  output logic                   readReadyA,
  output logic                   readReadyB,
  output logic                   commitValid,
  output logic [4:0]             commitRd,
  output logic                   commitWritesReg,
  output logic [WIDTH:0]         commitResult,
  output logic [ROB:0]           commitRob
);
  rob_entry_t     entries_q [DEPTH];
  rob_entry_t     entries_d [DEPTH];
  logic [ROB+1:0] head_q, head_d;
  logic [ROB+1:0] tail_q, tail_d;

  logic           commitValid_q, commitValid_d;
  logic [4:0]     commitRd_q, commitRd_d;
  logic           commitWritesReg_q, commitWritesReg_d;
  logic [WIDTH:0] commitResult_q, commitResult_d;
  logic [ROB:0]   commitRob_q, commitRob_d;

  logic full, empty, accept, do_commit;

  assign full       = (head_q[ROB:0] == tail_q[ROB:0]) && (head_q[ROB+1] != tail_q[ROB+1]);
  assign empty      = (head_q == tail_q);
  assign allocReady = !full;
  assign allocRob   = tail_q[ROB:0];
  assign accept     = allocValid && !full;
  assign do_commit  = !empty && entries_q[head_q[ROB:0]].busy && entries_q[head_q[ROB:0]].ready;

  always_comb begin
    entries_d         = entries_q;
    head_d            = head_q;
    tail_d            = tail_q;
    commitValid_d     = 1'b0;
    commitRd_d        = commitRd_q;
    commitWritesReg_d = commitWritesReg_q;
    commitResult_d    = commitResult_q;
    commitRob_d       = commitRob_q;

    // Broadcasts to idle slots are stale results from squashed work; drop them.
    if (dataBus.validBroadcast && entries_q[dataBus.robEntry].busy) begin
      entries_d[dataBus.robEntry].ready = 1'b1;
      entries_d[dataBus.robEntry].value = dataBus.result;
    end

    if (do_commit) begin
      commitValid_d     = 1'b1;
      commitRd_d        = entries_q[head_q[ROB:0]].rd;
      commitWritesReg_d = entries_q[head_q[ROB:0]].writesReg;
      commitResult_d    = entries_q[head_q[ROB:0]].value;
      commitRob_d       = head_q[ROB:0];
      entries_d[head_q[ROB:0]].busy = 1'b0;
      head_d            = head_q + 1'b1;
    end

    if (accept) begin
      entries_d[tail_q[ROB:0]].busy      = 1'b1;
      entries_d[tail_q[ROB:0]].ready     = 1'b0;
      entries_d[tail_q[ROB:0]].rd        = allocRd;
      entries_d[tail_q[ROB:0]].writesReg = allocWritesReg;
      tail_d            = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q            <= '0;
      tail_q            <= '0;
      commitValid_q     <= 1'b0;
      commitRd_q        <= '0;
      commitWritesReg_q <= 1'b0;
      commitResult_q    <= '0;
      commitRob_q       <= '0;
    end else begin
      entries_q         <= entries_d;
      head_q            <= head_d;
      tail_q            <= tail_d;
      commitValid_q     <= commitValid_d;
      commitRd_q        <= commitRd_d;
      commitWritesReg_q <= commitWritesReg_d;
      commitResult_q    <= commitResult_d;
      commitRob_q       <= commitRob_d;
    end
  end

  assign commitValid     = commitValid_q;
  assign commitRd        = commitRd_q;
  assign commitWritesReg = commitWritesReg_q;
  assign commitResult    = commitResult_q;
  assign commitRob       = commitRob_q;

  rob_read_port u_read_a (
    .entry_i     (entries_q[readRobA]),
    .hit_i       (dataBus.validBroadcast && (dataBus.robEntry == readRobA)),
    .cdbResult_i (dataBus.result),
    .ready_o     (readReadyA),
    .value_o     (readValueA)
  );

  rob_read_port u_read_b (
    .entry_i     (entries_q[readRobB]),
    .hit_i       (dataBus.validBroadcast && (dataBus.robEntry == readRobB)),
    .cdbResult_i (dataBus.result),
    .ready_o     (readReadyB),
    .value_o     (readValueB)
  );
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer with a per-cycle commit scoreboard.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        reset, flush, allocValid, allocWritesReg, allocReady;
  logic [4:0]  allocRd;
  logic [2:0]  allocRob, readRobA, readRobB, commitRob;
  logic [31:0] readValueA, readValueB, commitResult;
  logic        readReadyA, readReadyB, commitValid, commitWritesReg;
  logic [4:0]  commitRd;

  always #5 clk = ~clk;

  commonDataBus cdb ();

  reorder_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .allocValid(allocValid), .allocRd(allocRd), .allocWritesReg(allocWritesReg),
    .allocReady(allocReady), .allocRob(allocRob), .dataBus(cdb),
    .readRobA(readRobA), .readRobB(readRobB),
    .readValueA(readValueA), .readValueB(readValueB),
    .readReadyA(readReadyA), .readReadyB(readReadyB),
    .commitValid(commitValid), .commitRd(commitRd), .commitWritesReg(commitWritesReg),
    .commitResult(commitResult), .commitRob(commitRob)
  );

  int checks = 0;
  int errors = 0;

  // kind: 0 = no commit expected, 1 = commit expected, 2 = cleared by reset/flush
  typedef struct {
    int          kind;
    logic [2:0]  tag;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] val;
  } rec_t;
  rec_t exp_q[$];

  // Reference model: program-order queue of in-flight tags plus per-tag payload.
  int          order_q[$];
  bit          m_rdy [8];
  logic [31:0] m_val [8];
  logic [4:0]  m_rd  [8];
  bit          m_wr  [8];
  int          alloc_total = 0;
  bit          comb_chk = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_flight(int t);
    foreach (order_q[i]) if (order_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_read(string name, int tag, logic act_rdy, logic [31:0] act_val,
                            bit cv, int ctag, logic [31:0] cval);
    bit busy, fwd, exp_rdy;
    busy    = in_flight(tag);
    fwd     = cv && (ctag == tag);
    exp_rdy = busy && (m_rdy[tag] || fwd);
    chk({name, "_ready"}, {31'd0, act_rdy}, {31'd0, exp_rdy});
    if (!busy)        chk({name, "_idle_value"}, act_val, 32'd0);
    else if (exp_rdy) chk({name, "_value"}, act_val, fwd ? cval : m_val[tag]);
  endtask

  task automatic cycle(bit rst, bit fl, bit av, logic [4:0] ard, bit awr,
                       bit cv, int ctag, logic [31:0] cval, int ra, int rb);
    rec_t r;
    int   t;
    reset = rst; flush = fl; allocValid = av; allocRd = ard; allocWritesReg = awr;
    cdb.validBroadcast = cv; cdb.robEntry = 3'(ctag); cdb.result = cval;
    readRobA = 3'(ra); readRobB = 3'(rb);
    #1;
    if (!rst && comb_chk) begin
      chk("allocReady", {31'd0, allocReady}, {31'd0, order_q.size() < 8});
      chk("allocRob", {29'd0, allocRob}, 32'(alloc_total % 8));
      check_read("readA", ra, readReadyA, readValueA, cv, ctag, cval);
      check_read("readB", rb, readReadyB, readValueB, cv, ctag, cval);
    end
    r.kind = 0; r.tag = '0; r.rd = '0; r.wr = 1'b0; r.val = '0;
    if (rst || fl) begin
      order_q.delete();
      alloc_total = 0;
      foreach (m_rdy[i]) m_rdy[i] = 1'b0;
      r.kind = 2;
      comb_chk = 1'b1;
    end else begin
      bit accept, commit;
      accept = av && (order_q.size() < 8);
      commit = (order_q.size() > 0) && m_rdy[order_q[0]];
      if (commit) begin
        t = order_q[0];
        r.kind = 1; r.tag = 3'(t); r.rd = m_rd[t]; r.wr = m_wr[t]; r.val = m_val[t];
      end
      if (cv && in_flight(ctag)) begin
        m_rdy[ctag] = 1'b1;
        m_val[ctag] = cval;
      end
      if (commit) void'(order_q.pop_front());
      if (accept) begin
        t = alloc_total % 8;
        order_q.push_back(t);
        m_rdy[t] = 1'b0; m_rd[t] = ard; m_wr[t] = awr;
        alloc_total = (alloc_total + 1) % 16;
      end
    end
    exp_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic idle(int ra, int rb);
    cycle(0, 0, 0, 5'd0, 0, 0, 0, 32'd0, ra, rb);
  endtask

  // Monitor: one scoreboard record per rising edge; commit outputs hold otherwise.
  initial begin
    rec_t        e;
    logic [2:0]  h_tag = '0;
    logic [4:0]  h_rd  = '0;
    logic        h_wr  = 1'b0;
    logic [31:0] h_val = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expectation for edge at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == 2) begin
          h_tag = '0; h_rd = '0; h_wr = 1'b0; h_val = '0;
        end else if (e.kind == 1) begin
          h_tag = e.tag; h_rd = e.rd; h_wr = e.wr; h_val = e.val;
        end
        chk("commitValid", {31'd0, commitValid}, {31'd0, e.kind == 1});
        chk("commitRob", {29'd0, commitRob}, {29'd0, h_tag});
        chk("commitRd", {27'd0, commitRd}, {27'd0, h_rd});
        chk("commitWritesReg", {31'd0, commitWritesReg}, {31'd0, h_wr});
        chk("commitResult", commitResult, h_val);
      end
    end
  end

  initial begin
    cycle(1, 0, 0, 5'd0, 0, 0, 0, 32'd0, 0, 0);
    cycle(1, 0, 0, 5'd0, 0, 0, 0, 32'd0, 0, 0);
    idle(0, 7);

    // Fill all eight slots, then a ninth request that must be refused.
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 5'(i + 1), 1, 0, 0, 32'd0, i, 7 - i);
    cycle(0, 0, 1, 5'd31, 1, 0, 0, 32'd0, 0, 3);
    idle(7, 0);
    cycle(0, 1, 0, 5'd0, 0, 0, 0, 32'd0, 0, 0);

    // Out-of-order completion, in-order retire.
    cycle(0, 0, 1, 5'd3, 1, 0, 0, 32'd0, 0, 1);
    cycle(0, 0, 1, 5'd4, 0, 0, 0, 32'd0, 0, 1);
    cycle(0, 0, 0, 5'd0, 0, 1, 1, 32'h000000AA, 0, 1);
    cycle(0, 0, 0, 5'd0, 0, 1, 0, 32'h00000055, 0, 1);
    for (int i = 0; i < 3; i++) idle(0, 1);

    // Same-cycle forwarding on read port A.
    cycle(0, 1, 0, 5'd0, 0, 0, 0, 32'd0, 0, 0);
    cycle(0, 0, 1, 5'd9, 1, 0, 0, 32'd0, 0, 0);
    cycle(0, 0, 0, 5'd0, 0, 1, 0, 32'h00001234, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Wrap-around: fill, retire three, reuse tags 0..2.
    cycle(0, 1, 0, 5'd0, 0, 0, 0, 32'd0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 5'(i + 10), i[0], 0, 0, 32'd0, i, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 5'd0, 0, 1, i, 32'h100 + i, i, 7);
    for (int i = 0; i < 3; i++) idle(i, 3);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 5'(i + 20), 1, 0, 0, 32'd0, i, 5);
    idle(0, 1);

    // Broadcast to an idle tag is ignored; a later allocation of it is not ready.
    cycle(0, 1, 0, 5'd0, 0, 0, 0, 32'd0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 5'(i + 1), 1, 0, 0, 32'd0, 5, 0);
    cycle(0, 0, 0, 5'd0, 0, 1, 5, 32'hDEADBEEF, 5, 4);
    cycle(0, 0, 1, 5'd6, 1, 0, 0, 32'd0, 5, 4);
    idle(5, 5);

    // Flush together with allocation, broadcast and a pending commit.
    cycle(0, 1, 0, 5'd0, 0, 0, 0, 32'd0, 0, 0);
    cycle(0, 0, 1, 5'd7, 1, 0, 0, 32'd0, 0, 1);
    cycle(0, 0, 1, 5'd8, 1, 0, 0, 32'd0, 0, 1);
    cycle(0, 0, 0, 5'd0, 0, 1, 0, 32'h77, 0, 1);
    cycle(0, 1, 1, 5'd9, 1, 1, 1, 32'h88, 0, 1);
    idle(0, 1);

    // Randomized traffic, with occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      bit          av, awr, cv, fl, rst;
      int          ctag;
      logic [31:0] cval;
      av   = ($urandom_range(0, 9) < 6);
      awr  = 1'($urandom);
      cv   = 1'($urandom);
      cval = $urandom;
      if (order_q.size() > 0 && $urandom_range(0, 4) != 0)
        ctag = order_q[$urandom_range(0, order_q.size() - 1)];
      else
        ctag = $urandom_range(0, 7);
      fl  = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle(rst, fl, av, 5'($urandom), awr, cv, ctag, cval,
            $urandom_range(0, 7), $urandom_range(0, 7));
    end
    idle(0, 0);
    idle(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
